// File: rtl/pll_phase_pkg.sv
// Shared types and defaults for the PLL dynamic phase-step controller.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP_LO,
        S_STEP_HI,
        S_DONE,
        S_WAIT_LOCK
    } state_t;

    localparam int DEF_PHASE_RANGE     = 40;
    localparam int DEF_STEP_LOW_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES   = 16;
    localparam int TMR_W               = 16;

    // One step of the tracked phase, wrapping at 0 and at last.
    function automatic logic [7:0] phase_wrap(
        input logic [7:0] cur,
        input logic       adv,
        input logic [7:0] last
    );
        if (adv)
            return (cur == last) ? 8'd0 : cur + 8'd1;
        return (cur == 8'd0) ? last : cur - 8'd1;
    endfunction

endpackage

// File: rtl/pll_step_timer.sv
// Loadable down-counter; o_zero flags the final cycle of an interval.
module pll_step_timer
    import pll_phase_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Drives PLL PHASE_SEL/DIR/STEP_N/LOAD_PHASE for N-step phase shifts.
// Optional cur_phase tracking is built only when PLL_PHASE_TRACK_EN is defined.
module pll_phase_step_ctrl
    import pll_phase_pkg::*;
#(
    parameter int PHASE_RANGE     = DEF_PHASE_RANGE,
    parameter int STEP_LOW_CYCLES = DEF_STEP_LOW_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_count,
    output logic [2:0] phase_sel,
    output logic       phase_dir,
    output logic       phase_step_n,
    output logic       load_phase,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] cur_phase
);

    localparam logic [TMR_W-1:0] LO_LD = TMR_W'(STEP_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] HI_LD = TMR_W'(SETTLE_CYCLES - 1);

    if (PHASE_RANGE < 2 || PHASE_RANGE > 256) begin : g_bad_range
        $error("PHASE_RANGE must be 2..256");
    end
    if (STEP_LOW_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
        $error("STEP_LOW_CYCLES and SETTLE_CYCLES must be >= 1");
    end

    state_t           r_state;
    logic [2:0]       r_sel;
    logic             r_dir;
    logic [7:0]       r_rem;
    logic             r_step_n;
    logic             r_load;
    logic             r_done;
    logic             r_err;
    logic             w_zero;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;

    // Reload the timer on every edge that enters STEP_LO or STEP_HI.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = LO_LD;
        if (pll_lock) begin
            unique case (r_state)
                S_LOAD: w_tmr_load = 1'b1;
                S_STEP_LO: begin
                    w_tmr_load = w_zero;
                    w_tmr_val  = HI_LD;
                end
                S_STEP_HI: w_tmr_load = w_zero && (r_rem != 8'd0);
                default: w_tmr_load = 1'b0;
            endcase
        end
    end

    pll_step_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_zero)
    );

`ifdef PLL_PHASE_TRACK_EN
    localparam logic [7:0] PH_LAST = 8'(PHASE_RANGE - 1);
    logic [7:0] r_phase;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_dir    <= 1'b0;
            r_rem    <= '0;
            r_step_n <= 1'b1;
            r_load   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef PLL_PHASE_TRACK_EN
            r_phase  <= '0;
`endif
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Lock loss outranks any interval expiry in the same cycle.
            if (!pll_lock && (r_state == S_LOAD || r_state == S_STEP_LO ||
                              r_state == S_STEP_HI)) begin
                r_state  <= S_WAIT_LOCK;
                r_err    <= 1'b1;
                r_step_n <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (req_valid && pll_lock) begin
                            r_sel <= req_sel;
                            r_dir <= req_dir;
                            r_rem <= req_count;
                            if (req_count == 8'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                                r_load  <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_state  <= S_STEP_LO;
                        r_step_n <= 1'b0;
                    end
                    S_STEP_LO: begin
                        if (w_zero) begin
                            r_state  <= S_STEP_HI;
                            r_step_n <= 1'b1;
                            r_rem    <= r_rem - 8'd1;
`ifdef PLL_PHASE_TRACK_EN
                            r_phase  <= phase_wrap(r_phase, r_dir, PH_LAST);
`endif
                        end
                    end
                    S_STEP_HI: begin
                        if (w_zero) begin
                            if (r_rem != 8'd0) begin
                                r_state  <= S_STEP_LO;
                                r_step_n <= 1'b0;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    S_WAIT_LOCK: begin
                        if (pll_lock)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE) && pll_lock;
    assign busy         = (r_state != S_IDLE);
    assign phase_sel    = r_sel;
    assign phase_dir    = r_dir;
    assign phase_step_n = r_step_n;
    assign load_phase   = r_load;
    assign done         = r_done;
    assign err          = r_err;
`ifdef PLL_PHASE_TRACK_EN
    assign cur_phase    = r_phase;
`else
    assign cur_phase    = '0;
`endif

endmodule
